// File: rtl/mem_exec_pkg.sv
// mem_exec_pkg: shared types for the memory execution unit.
// Exports op_t, state_t and align_mask().
package mem_exec_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    MOVE  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    LD_DRAIN,
    LD_REQ,
    RESP
  } state_t;

  // Low address bits that must be zero for a word access.
  function automatic int unsigned align_mask(
    input int unsigned data_w
  );
    return (data_w / 8) - 1;
  endfunction

endpackage

// File: rtl/mem_exec_store_buffer.sv
// mem_exec_store_buffer: FIFO of posted stores.
// Ports: push, head/pop, count flags; the youngest-match lookup
// (i_lk_addr/o_lk_hit/o_lk_data) exists only with MEM_EXEC_FORWARD_EN.
module mem_exec_store_buffer
  import mem_exec_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef MEM_EXEC_FORWARD_EN
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_lk_hit,
  output logic [DATA_W-1:0] o_lk_data,
`endif
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop_ready,
  output logic              o_head_valid,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = !o_empty && i_pop_ready;

  assign o_head_valid = !o_empty;
  assign o_head_addr  = o_empty ? '0 : r_addr[r_rd_ptr];
  assign o_head_data  = o_empty ? '0 : r_data[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is never read while its slot is invalid: no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

`ifdef MEM_EXEC_FORWARD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < r_count &&
          r_addr[w_idx] == i_lk_addr) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_data[w_idx];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_exec_unit.sv
// mem_exec_unit: load/store unit with posted store buffer.
// Ports: req_*, resp_*, mem_wr_*, mem_rd_*, sb_empty.
// Define MEM_EXEC_FORWARD_EN for store-to-load forwarding.
module mem_exec_unit
  import mem_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              sb_empty
);

  localparam logic [ADDR_W-1:0] ALIGN_M =
    ADDR_W'(align_mask(DATA_W));

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_resp_data;
  logic [DATA_W-1:0] w_resp_data_nxt;
  logic              r_resp_fault;
  logic              w_resp_fault_nxt;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [ADDR_W-1:0] w_ld_addr_nxt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_mis;
  logic              w_accept;
  logic              w_push;
  logic              w_sb_full;
  logic              w_sb_empty;
  logic              w_ldst;

  assign w_addr   = req_base + req_offset;
  assign w_mis    = |(w_addr & ALIGN_M);
  assign w_ldst   = (req_op == LOAD) || (req_op == STORE);
  // Gated by reset_n so nothing is accepted while reset is held.
  assign req_ready = reset_n && (r_state == IDLE) && !w_sb_full;
  assign w_accept  = req_valid && req_ready;

  assign resp_valid   = (r_state == RESP);
  assign resp_data    = r_resp_data;
  assign resp_fault   = r_resp_fault;
  assign mem_rd_valid = (r_state == LD_REQ);
  assign mem_rd_addr  = r_ld_addr;
  assign sb_empty     = w_sb_empty;

`ifdef MEM_EXEC_FORWARD_EN
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
`endif

  mem_exec_store_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef MEM_EXEC_FORWARD_EN
    .i_lk_addr    (w_addr),
    .o_lk_hit     (w_hit),
    .o_lk_data    (w_hit_data),
`endif
    .i_push       (w_push),
    .i_push_addr  (w_addr),
    .i_push_data  (req_data),
    .i_pop_ready  (mem_wr_ready),
    .o_head_valid (mem_wr_valid),
    .o_head_addr  (mem_wr_addr),
    .o_head_data  (mem_wr_data),
    .o_full       (w_sb_full),
    .o_empty      (w_sb_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
      r_ld_addr    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_fault <= w_resp_fault_nxt;
      r_ld_addr    <= w_ld_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_resp_data_nxt  = r_resp_data;
    w_resp_fault_nxt = r_resp_fault;
    w_ld_addr_nxt    = r_ld_addr;
    w_push           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt      = RESP;
          w_resp_data_nxt  = '0;
          w_resp_fault_nxt = 1'b0;
          unique case (1'b1)
            req_op == MOVE:
              w_resp_data_nxt = req_data;
            w_ldst && w_mis:
              w_resp_fault_nxt = 1'b1;
            req_op == STORE && !w_mis:
              w_push = 1'b1;
            req_op == LOAD && !w_mis: begin
              w_ld_addr_nxt = w_addr;
`ifdef MEM_EXEC_FORWARD_EN
              if (w_hit)
                w_resp_data_nxt = w_hit_data;
              else
                w_state_nxt = LD_REQ;
`else
              // Memory must see every older store first.
              w_state_nxt = w_sb_empty ? LD_REQ
                                       : LD_DRAIN;
`endif
            end
            default: ;
          endcase
        end
      end
      LD_DRAIN: begin
        if (w_sb_empty) w_state_nxt = LD_REQ;
      end
      LD_REQ: begin
        if (mem_rd_ready) begin
          w_resp_data_nxt = mem_rd_data;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt      = IDLE;
          w_resp_data_nxt  = '0;
          w_resp_fault_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_exec_unit.sv
// tb_mem_exec_unit: directed checks for mem_exec_unit.
// Works with or without MEM_EXEC_FORWARD_EN.
module tb_mem_exec_unit;
  import mem_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        sb_empty;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mem_exec_unit #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .SB_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_fault   (resp_fault),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .sb_empty     (sb_empty)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request, wait (bounded) for ready, return at T+1.
  task automatic send(input op_t op,
                      input logic [31:0] b,
                      input logic [31:0] o,
                      input logic [31:0] d);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_op     = op;
    req_base   = b;
    req_offset = o;
    req_data   = d;
    #1;
    while (!req_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk("send_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_op       = NOP;
    req_base     = '0;
    req_offset   = '0;
    req_data     = '0;
    resp_ready   = 1'b1;
    mem_wr_ready = 1'b1;
    mem_rd_ready = 1'b0;
    mem_rd_data  = '0;

    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_rd_valid", mem_rd_valid, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_sb_empty", sb_empty, 1);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);

    // single store, drains immediately
    send(STORE, 32'h100, 32'h4, 32'hDEADBEEF);
    #1;
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_data", resp_data, 0);
    chk("st_resp_fault", resp_fault, 0);
    chk("st_wr_valid", mem_wr_valid, 1);
    chk("st_wr_addr", mem_wr_addr, 32'h104);
    chk("st_wr_data", mem_wr_data, 32'hDEADBEEF);
    chk("st_sb_empty0", sb_empty, 0);
    tick();
    #1;
    chk("st_sb_empty1", sb_empty, 1);
    chk("st_wr_valid0", mem_wr_valid, 0);
    chk("st_resp_done", resp_valid, 0);

    // fill the buffer, fifth store waits for a pop
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(STORE, 32'h10, 32'(4 * k), 32'(k + 1));
    tick();
    #1;
    chk("full_ready", req_ready, 0);
    chk("full_head", mem_wr_addr, 32'h10);
    req_valid  = 1'b1;
    req_op     = STORE;
    req_base   = 32'h20;
    req_offset = 32'h0;
    req_data   = 32'h5;
    tick();
    #1;
    chk("full_hold", req_ready, 0);
    chk("full_resp", resp_valid, 0);
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    #1;
    chk("pop_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    exp_a[0] = 32'h14; exp_d[0] = 32'h2;
    exp_a[1] = 32'h18; exp_d[1] = 32'h3;
    exp_a[2] = 32'h1C; exp_d[2] = 32'h4;
    exp_a[3] = 32'h20; exp_d[3] = 32'h5;
    mem_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", mem_wr_valid, 1);
      chk("drain_addr", mem_wr_addr, exp_a[k]);
      chk("drain_data", mem_wr_data, exp_d[k]);
      tick();
    end
    #1;
    chk("drain_empty", sb_empty, 1);

    // load after two stores to the same address
    mem_wr_ready = 1'b0;
    send(STORE, 32'h200, 32'h0, 32'h11);
    send(STORE, 32'h200, 32'h0, 32'h22);
    send(LOAD, 32'h200, 32'h0, 32'h0);
    #1;
`ifdef MEM_EXEC_FORWARD_EN
    chk("fwd_valid", resp_valid, 1);
    chk("fwd_data", resp_data, 32'h22);
    chk("fwd_no_rd", mem_rd_valid, 0);
`else
    chk("ldd_no_resp", resp_valid, 0);
    chk("ldd_no_rd", mem_rd_valid, 0);
    tick();
    tick();
    #1;
    chk("ldd_wait_rd", mem_rd_valid, 0);
    chk("ldd_wait_se", sb_empty, 0);
    mem_wr_ready = 1'b1;
    n = 0;
    while (!mem_rd_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("ldd_rd_valid", mem_rd_valid, 1);
    chk("ldd_rd_empty", sb_empty, 1);
    chk("ldd_rd_addr", mem_rd_addr, 32'h200);
    mem_rd_ready = 1'b1;
    mem_rd_data  = 32'h33;
    tick();
    mem_rd_ready = 1'b0;
    mem_rd_data  = '0;
    #1;
    chk("ldd_resp", resp_valid, 1);
    chk("ldd_data", resp_data, 32'h33);
`endif
    mem_wr_ready = 1'b1;
    repeat (4) tick();
    #1;
    chk("ld_sb_empty", sb_empty, 1);

    // load miss with slow memory
    send(LOAD, 32'h300, 32'h0, 32'h0);
    #1;
    chk("miss_rd_valid", mem_rd_valid, 1);
    chk("miss_rd_addr", mem_rd_addr, 32'h300);
    chk("miss_no_resp", resp_valid, 0);
    tick();
    tick();
    #1;
    chk("miss_rd_hold", mem_rd_valid, 1);
    chk("miss_addr_hold", mem_rd_addr, 32'h300);
    mem_rd_ready = 1'b1;
    mem_rd_data  = 32'hCAFEF00D;
    tick();
    mem_rd_ready = 1'b0;
    mem_rd_data  = '0;
    #1;
    chk("miss_resp", resp_valid, 1);
    chk("miss_data", resp_data, 32'hCAFEF00D);
    chk("miss_rd_done", mem_rd_valid, 0);
    tick();

    // misaligned load and store, NOP
    send(LOAD, 32'h400, 32'h2, 32'h0);
    #1;
    chk("mis_ld_fault", resp_fault, 1);
    chk("mis_ld_data", resp_data, 0);
    chk("mis_ld_rd", mem_rd_valid, 0);
    tick();
    send(STORE, 32'h401, 32'h0, 32'h77);
    #1;
    chk("mis_st_fault", resp_fault, 1);
    chk("mis_st_nopush", sb_empty, 1);
    tick();
    send(NOP, 32'h0, 32'h0, 32'h99);
    #1;
    chk("nop_valid", resp_valid, 1);
    chk("nop_data", resp_data, 0);
    chk("nop_fault", resp_fault, 0);
    tick();

    // move with a stalled response
    resp_ready = 1'b0;
    send(MOVE, 32'h0, 32'h0, 32'h5A);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mv_valid", resp_valid, 1);
      chk("mv_data", resp_data, 32'h5A);
      chk("mv_fault", resp_fault, 0);
      chk("mv_ready_low", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("mv_hs_ready", req_ready, 0);
    tick();
    #1;
    chk("mv_done", resp_valid, 0);
    chk("mv_idle_ready", req_ready, 1);

    // reset with buffered stores and a pending load
    mem_wr_ready = 1'b0;
    send(STORE, 32'h500, 32'h0, 32'h1);
    send(STORE, 32'h504, 32'h0, 32'h2);
    send(LOAD, 32'h600, 32'h0, 32'h0);
    #1;
    chk("pre_rst_wr", mem_wr_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", mem_wr_valid, 0);
    chk("mid_rst_rd", mem_rd_valid, 0);
    chk("mid_rst_resp", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_empty", sb_empty, 1);
    tick();
    reset_n      = 1'b1;
    mem_wr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("post_rst_nowr", mem_wr_valid, 0);
      chk("post_rst_nord", mem_rd_valid, 0);
      tick();
    end
    #1;
    chk("post_rst_rdy2", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
